// File: rtl/ofifo_pkg.sv
// Shared constants and width helpers for the output FIFO aligner.
// Optional feature macro: OFIFO_OVERFLOW_FLAG_EN (adds sticky o_overflow).
package ofifo_pkg;

   localparam int COL_DEF     = 8;
   localparam int PSUM_BW_DEF = 16;
   localparam int DEPTH_DEF   = 64;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One psum lane: circular storage, wrap-around pointers and occupancy count.
// Pops are only issued by the aligner when every lane is non-empty.
module ofifo_lane
   import ofifo_pkg::*;
#(
   parameter int PSUM_BW = PSUM_BW_DEF,
   parameter int DEPTH   = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PSUM_BW-1:0] i_din,
   input  logic               i_wr,
   input  logic               i_pop,
   output logic [PSUM_BW-1:0] o_head,
   output logic               o_nempty,
   output logic               o_full
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PSUM_BW-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic [CW-1:0]      r_count;
   logic               w_wr_ok;

   assign o_full   = (r_count == FULL_CNT);
   assign o_nempty = (r_count != '0);
   assign o_head   = r_mem[r_rptr];
   assign w_wr_ok  = i_wr & ~o_full;

   // Storage is intentionally not reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[r_wptr] <= i_din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_ok)
            r_wptr <= r_wptr + PW'(1);
         if (i_pop)
            r_rptr <= r_rptr + PW'(1);
         case ({w_wr_ok, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ofifo_align.sv
// Per-column output FIFOs re-aligning skewed array psums into whole rows.
// Define OFIFO_OVERFLOW_FLAG_EN to add the sticky o_overflow output.
module ofifo_align
   import ofifo_pkg::*;
#(
   parameter int COL     = COL_DEF,
   parameter int PSUM_BW = PSUM_BW_DEF,
   parameter int DEPTH   = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PSUM_BW*COL-1:0] in,
   input  logic [COL-1:0]         wr,
   input  logic                   rd,
   output logic [PSUM_BW*COL-1:0] out,
   output logic [COL-1:0]         out_valid,
   output logic                   o_valid,
   output logic                   o_ready,
   output logic                   o_full
`ifdef OFIFO_OVERFLOW_FLAG_EN
   ,
   output logic                   o_overflow
`endif
);

   logic [PSUM_BW*COL-1:0] w_head;
   logic [COL-1:0]         w_nempty;
   logic [COL-1:0]         w_lfull;
   logic                   w_pop;
   logic [PSUM_BW*COL-1:0] r_out;
   logic [COL-1:0]         r_out_valid;

   for (genvar k = 0; k < COL; k++) begin : g_lane
      ofifo_lane #(
         .PSUM_BW (PSUM_BW),
         .DEPTH   (DEPTH)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .i_din    (in[k*PSUM_BW +: PSUM_BW]),
         .i_wr     (wr[k]),
         .i_pop    (w_pop),
         .o_head   (w_head[k*PSUM_BW +: PSUM_BW]),
         .o_nempty (w_nempty[k]),
         .o_full   (w_lfull[k])
      );
   end

   assign o_valid   = &w_nempty;
   assign o_full    = |w_lfull;
   assign o_ready   = ~o_full;
   // A row leaves only when every lane has its element.
   assign w_pop     = rd & o_valid;
   assign out       = r_out;
   assign out_valid = r_out_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out       <= '0;
         r_out_valid <= '0;
      end else begin
         r_out_valid <= {COL{w_pop}};
         if (w_pop)
            r_out <= w_head;
      end
   end

`ifdef OFIFO_OVERFLOW_FLAG_EN
   logic r_ovf;

   assign o_overflow = r_ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_ovf <= 1'b0;
      else if (|(wr & w_lfull))
         r_ovf <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ofifo_align.sv
// Scoreboard bench for ofifo_align: per-lane queue model feeds expected rows.
// Build with OFIFO_OVERFLOW_FLAG_EN to also check the sticky overflow flag.
module tb_ofifo_align;

   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int DEP = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic [BW*COL-1:0] in_v;
   logic [COL-1:0]   wr_v;
   logic             rd_v;
   logic [BW*COL-1:0] out;
   logic [COL-1:0]   out_valid;
   logic             o_valid, o_ready, o_full;
`ifdef OFIFO_OVERFLOW_FLAG_EN
   logic             o_overflow;
`endif

   ofifo_align #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_v),
      .wr        (wr_v),
      .rd        (rd_v),
      .out       (out),
      .out_valid (out_valid),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_full    (o_full)
`ifdef OFIFO_OVERFLOW_FLAG_EN
      ,
      .o_overflow(o_overflow)
`endif
   );

   always #5 clk = ~clk;

   logic [BW-1:0]     lq [0:COL-1][$];
   logic [BW*COL-1:0] sb [$];
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  pend;
   bit  exp_ovf = 0;

   function automatic logic [BW*COL-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: drive at negedge, update model with pre-edge state,
   // return #1 after the rising edge.
   task automatic cyc(input logic [COL-1:0] w, input logic [BW*COL-1:0] d,
                      input logic r);
      bit vld;
      bit fl [COL];
      logic [BW*COL-1:0] row;
      @(negedge clk);
      wr_v = w; in_v = d; rd_v = r;
      vld = 1;
      for (int i = 0; i < COL; i++) begin
         if (lq[i].size() == 0) vld = 0;
         fl[i] = (lq[i].size() >= DEP);
      end
      pend = r && vld;
      if (pend) begin
         for (int i = 0; i < COL; i++) row[i*BW +: BW] = lq[i].pop_front();
         sb.push_back(row);
      end
      for (int i = 0; i < COL; i++)
         if (w[i]) begin
            if (fl[i]) exp_ovf = 1;
            else lq[i].push_back(d[i*BW +: BW]);
         end
      @(posedge clk);
      #1;
      wr_v = '0; rd_v = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_v = '0; rd_v = 1'b0; in_v = '0;
      #1;
      n_cmp++;
      if ({o_valid, o_ready, o_full} !== 3'b010) begin
         n_bad++;
         $display("FAIL reset_flags got v/r/f=%b%b%b want 010",
                  o_valid, o_ready, o_full);
      end
      n_cmp++;
      if (out_valid !== 8'h00 || out !== '0) begin
         n_bad++;
         $display("FAIL reset_out got %h/%h want 0/0", out_valid, out);
      end
`ifdef OFIFO_OVERFLOW_FLAG_EN
      n_cmp++;
      if (o_overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ovf got %b want 0", o_overflow);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_skew();
      logic [BW*COL-1:0] d, row, want;
      for (int k = 0; k < COL; k++) begin
         d = '0;
         d[k*BW +: BW] = 16'h0100 + 16'(k);
         want[k*BW +: BW] = 16'h0100 + 16'(k);
         cyc(8'(1 << k), d, 1'b0);
         n_cmp++;
         if (o_valid !== (k == COL-1)) begin
            n_bad++;
            $display("FAIL skew_valid lane %0d got %b want %b",
                     k, o_valid, k == COL-1);
         end
      end
      cyc('0, '0, 1'b1);
      row = pend ? sb.pop_front() : '0;
      n_cmp++;
      if (!pend || out !== want || out !== row || out_valid !== 8'hFF) begin
         n_bad++;
         $display("FAIL skew_row got %h/%h want %h/ff", out, out_valid, want);
      end
      cyc('0, '0, 1'b0);
      n_cmp++;
      if (out_valid !== 8'h00 || out !== want || o_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL skew_hold got %h/%h v=%b want %h/00 v=0",
                  out, out_valid, o_valid, want);
      end
   endtask

   task automatic test_empty_pop();
      logic [BW*COL-1:0] row;
      cyc(8'hDF, rnd(), 1'b0);
      cyc('0, '0, 1'b1);
      n_cmp++;
      if (out_valid !== 8'h00 || o_valid !== 1'b0 || pend) begin
         n_bad++;
         $display("FAIL empty_pop got ov=%h v=%b want 00 v=0",
                  out_valid, o_valid);
      end
      cyc(8'h20, rnd(), 1'b0);
      n_cmp++;
      if (o_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL empty_refill_valid got %b want 1", o_valid);
      end
      cyc('0, '0, 1'b1);
      row = pend ? sb.pop_front() : '0;
      n_cmp++;
      if (!pend || out !== row || out_valid !== 8'hFF) begin
         n_bad++;
         $display("FAIL empty_after_row got %h/%h want %h/ff",
                  out, out_valid, row);
      end
   endtask

   task automatic test_full();
      logic [BW*COL-1:0] d, row;
      int bad;
      for (int i = 0; i < DEP; i++) begin
         d = rnd();
         d[3*BW +: BW] = 16'h3000 + 16'(i);
         cyc(8'h08, d, 1'b0);
      end
      n_cmp++;
      if (o_full !== 1'b1 || o_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_flags got f=%b r=%b want f=1 r=0",
                  o_full, o_ready);
      end
      d = '0;
      d[3*BW +: BW] = 16'hDEAD;
      cyc(8'h08, d, 1'b0);
      n_cmp++;
      if (o_full !== 1'b1 || o_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_drop_flags got f=%b r=%b want f=1 r=0",
                  o_full, o_ready);
      end
`ifdef OFIFO_OVERFLOW_FLAG_EN
      n_cmp++;
      if (o_overflow !== exp_ovf) begin
         n_bad++;
         $display("FAIL full_ovf got %b want %b", o_overflow, exp_ovf);
      end
`endif
      for (int i = 0; i < DEP; i++) cyc(8'hF7, rnd(), 1'b0);
      bad = 0;
      for (int i = 0; i < DEP; i++) begin
         cyc('0, '0, 1'b1);
         row = pend ? sb.pop_front() : '0;
         n_cmp++;
         if (!pend || out !== row || out_valid !== 8'hFF) begin
            n_bad++;
            if (bad++ < 4)
               $display("FAIL full_drain row %0d got %h/%h want %h/ff",
                        i, out, out_valid, row);
         end
      end
      n_cmp++;
      if (o_valid !== 1'b0 || o_full !== 1'b0) begin
         n_bad++;
         $display("FAIL full_empty got v=%b f=%b want 0/0", o_valid, o_full);
      end
   endtask

   task automatic test_wrap();
      logic [BW*COL-1:0] row;
      int bad = 0;
      cyc(8'hFF, rnd(), 1'b0);
      for (int i = 0; i < 200; i++) begin
         cyc(8'hFF, rnd(), 1'b1);
         row = pend ? sb.pop_front() : '0;
         n_cmp++;
         if (!pend || out !== row || out_valid !== 8'hFF ||
             o_valid !== 1'b1 || o_full !== 1'b0) begin
            n_bad++;
            if (bad++ < 4)
               $display("FAIL wrap row %0d got %h/%h v=%b want %h/ff v=1",
                        i, out, out_valid, o_valid, row);
         end
      end
      cyc('0, '0, 1'b1);
      row = pend ? sb.pop_front() : '0;
      n_cmp++;
      if (!pend || out !== row || o_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_last got %h v=%b want %h v=0", out, o_valid, row);
      end
   endtask

   task automatic test_reset_mid();
      logic [BW*COL-1:0] r1, row;
      for (int i = 0; i < 11; i++) cyc(8'hFF, rnd(), 1'b0);
      cyc('0, '0, 1'b1);
      row = pend ? sb.pop_front() : '0;
      n_cmp++;
      if (!pend || out !== row || out_valid !== 8'hFF) begin
         n_bad++;
         $display("FAIL mid_prepop got %h/%h want %h/ff", out, out_valid, row);
      end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (o_valid !== 1'b0 || out_valid !== 8'h00 ||
          o_ready !== 1'b1 || out !== '0) begin
         n_bad++;
         $display("FAIL mid_reset got v=%b ov=%h r=%b out=%h want 0/00/1/0",
                  o_valid, out_valid, o_ready, out);
      end
      for (int i = 0; i < COL; i++) lq[i].delete();
      sb.delete();
      exp_ovf = 0;
`ifdef OFIFO_OVERFLOW_FLAG_EN
      n_cmp++;
      if (o_overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_ovf_clear got %b want 0", o_overflow);
      end
`endif
      @(negedge clk) reset = 1'b0;
      r1 = rnd();
      cyc(8'hFF, r1, 1'b0);
      cyc(8'hFF, rnd(), 1'b0);
      cyc('0, '0, 1'b1);
      row = pend ? sb.pop_front() : '0;
      n_cmp++;
      if (!pend || out !== r1 || out !== row || out_valid !== 8'hFF) begin
         n_bad++;
         $display("FAIL mid_first_row got %h/%h want %h/ff", out, out_valid, r1);
      end
   endtask

   initial begin
      test_reset();
      test_skew();
      test_empty_pop();
      test_full();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ofifo_align.md
OFIFO_ALIGN -- requirements
Module: ofifo_align

Interface
REQ-001 SHALL have parameter COL, default 8, meaning number of array columns / psum lanes.
REQ-002 SHALL have parameter PSUM_BW, default 16, meaning psum width per lane in bits.
REQ-003 SHALL have parameter DEPTH, default 64, meaning entries per column FIFO, a power of two ≥ 2.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, PSUM_BW*COL bits: psums from the array bottom row, lane k at [(k+1)*PSUM_BW-1 : k*PSUM_BW].
REQ-007 SHALL have port wr, input, COL bits: per-lane write strobe from the array.
REQ-008 SHALL have port rd, input, 1 bit: aligned-row pop request from the controller.
REQ-009 SHALL have port out, output, PSUM_BW*COL bits: aligned psum row to the SFP, same lane packing as in.
REQ-010 SHALL have port out_valid, output, COL bits: per-lane valid for out, driving the SFP's OFIFO-valid input.
REQ-011 SHALL have port o_valid, output, 1 bit: every lane holds at least one entry.
REQ-012 SHALL have port o_ready, output, 1 bit: no lane is full.
REQ-013 SHALL have port o_full, output, 1 bit: at least one lane is full.

Function
REQ-014 SHALL contain COL independent FIFOs, each DEPTH deep and PSUM_BW wide, with wrap-around read/write pointers of log2(DEPTH) bits.
REQ-015 SHALL hold a per-lane occupancy count of log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-016 SHALL drive o_valid, o_ready and o_full combinationally from the current occupancy counts.
REQ-017 SHALL accept a write to lane k at a rising edge when wr[k]=1 and count[k]<DEPTH (count before the edge).
REQ-018 SHALL drop a write to a full lane, even when a pop occurs in the same cycle; no pointer or count changes on the write side.
REQ-019 SHALL accept a pop when rd=1 and o_valid=1 (pre-edge); a pop advances all COL read pointers together.
REQ-020 SHALL ignore rd when o_valid=0; no state changes and out_valid goes to 0 on the next edge.
REQ-021 SHALL register the popped heads into out one cycle after an accepted pop, and set out_valid to all ones for exactly that one cycle.
REQ-022 SHALL set out_valid to 0 in any cycle after a non-accepted or absent pop, while out holds its last value.
REQ-023 SHALL leave a lane's count unchanged when that lane is written and popped in the same cycle.
REQ-024 SHALL not let a word written in cycle t be popped before cycle t+1; there is no fall-through.
REQ-025 SHALL support back-to-back pops every cycle while o_valid stays 1.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all pointers and counts, out to 0 and out_valid to 0, giving o_valid=0, o_ready=1, o_full=0.
REQ-027 SHALL discard any in-flight data on reset mid-operation; FIFO storage contents need not be cleared.

Configuration
REQ-028 SHALL, with macro OFIFO_OVERFLOW_FLAG_EN defined, add output o_overflow (1 bit): a sticky flag set on the edge after any dropped write and cleared only by reset.
REQ-029 SHALL, without OFIFO_OVERFLOW_FLAG_EN, omit the o_overflow port and its logic; dropped writes are silent.

Structure
REQ-030 SHALL place the default COL, PSUM_BW and DEPTH constants and the pointer/count width helper in the shared package ofifo_pkg.
REQ-031 SHALL implement one lane as sub-module ofifo_lane, instantiated COL times, carrying storage, pointers and count; the top-level module carries the alignment, pop and output register logic.

Verification
REQ-032 SHALL cover skewed fill: wr asserted lane k at cycle k for k=0..7 with in lane k = 16'h0100+k, then rd=1 -> o_valid rises after lane 7 is written; out = {16'h0107..16'h0100} with out_valid = 8'hFF one cycle after the pop.
REQ-033 SHALL cover full: 64 writes to lane 3 only, then a 65th write -> o_full=1, o_ready=0, count stays 64; with OFIFO_OVERFLOW_FLAG_EN, o_overflow=1 next cycle.
REQ-034 SHALL cover empty pop: rd=1 with lane 5 empty and other lanes holding data -> no pointer moves, out_valid = 0.
REQ-035 SHALL cover wrap-around: 200 rows streamed with simultaneous write and pop each cycle at occupancy 1 -> out matches the written sequence in order and counts never exceed 2.
REQ-036 SHALL cover reset mid-stream: reset asserted with 10 rows queued -> o_valid=0 and out_valid=0 immediately; the first row written after reset is the first popped.
